// File: rtl/hm_disp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hm_disp_ctrl_pkg
//   Shared definitions for the hour/minute display sequencer:
//   state encoding, display-mux select values and a small state helper.
// ---------------------------------------------------------------------------
package hm_disp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN_H = 2'd0,
        ST_RUN_M = 2'd1,
        ST_SET_H = 2'd2,
        ST_SET_M = 2'd3
    } hm_state_t;

    localparam logic SEL_HOUR = 1'b0;
    localparam logic SEL_MIN  = 1'b1;

    // True in either edit state.
    function automatic logic is_set_state(input hm_state_t st);
        return (st == ST_SET_H) || (st == ST_SET_M);
    endfunction

endpackage

// File: rtl/hm_tick_cnt.sv
// ---------------------------------------------------------------------------
// hm_tick_cnt
//   Clear/enable tick counter. Counts enabled cycles from 0 up to LIMIT-1;
//   the enabled cycle that finds the count at LIMIT-1 raises 'hit' and the
//   count returns to 0, so the value never exceeds LIMIT-1.
//   Ports:
//     clk   in  clock
//     rst_n in  asynchronous reset, active-low
//     clr   in  synchronous clear (wins over en)
//     en    in  count enable
//     hit   out combinational, 1 when en is high and count is LIMIT-1
// ---------------------------------------------------------------------------
module hm_tick_cnt #(
    parameter int CW    = 6,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    assign hit = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= hit ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hm_disp_ctrl.sv
// ---------------------------------------------------------------------------
// hm_disp_ctrl
//   Sequencer for the shared hour/minute display mux.
//   RUN: alternate hours/minutes every DWELL ticks.
//   SET: hold sel on the edited field, blink it every BLINK ticks and turn
//        btn_inc into a one-cycle inc_h / inc_m pulse.
//   Optional build macro HM_TIMEOUT_EN: leave SET for RUN_H after TIMEOUT
//   idle ticks. Without it SET is left only via btn_mode or reset.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     tick              one-cycle time-base enable
//     btn_mode, btn_inc debounced one-cycle button pulses
//     sel               display mux select (0 hours, 1 minutes)
//     blank             1 = display blanked
//     inc_h, inc_m      one-cycle increment pulses
//     set_mode          1 while editing
//     dbg_state         current FSM state, for observation
//   Handshake: no valid/ready; every input is a single-cycle pulse sampled
//   on the rising edge and every output reflects registered state, so an
//   input's effect appears one cycle later.
// ---------------------------------------------------------------------------
module hm_disp_ctrl
    import hm_disp_ctrl_pkg::*;
#(
    parameter int CW      = 6,
    parameter int DWELL   = 4,
    parameter int BLINK   = 2,
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sel,
    output logic       blank,
    output logic       inc_h,
    output logic       inc_m,
    output logic       set_mode,
    output logic [1:0] dbg_state
);

    hm_state_t state, next_state;
    logic      next_blank, next_inc_h, next_inc_m;

    logic in_set, in_run;
    logic dwell_hit, blink_hit, idle_hit;

    assign in_set = is_set_state(state);
    assign in_run = !in_set;

    // Dwell: counts ticks in RUN; any mode press restarts it.
    hm_tick_cnt #(.CW(CW), .LIMIT(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_set || btn_mode),
        .en    (in_run && tick && !btn_mode),
        .hit   (dwell_hit)
    );

`ifdef HM_TIMEOUT_EN
    // Idle: counts ticks in SET without any button activity.
    hm_tick_cnt #(.CW(CW), .LIMIT(TIMEOUT)) u_idle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_run || btn_mode || btn_inc),
        .en    (in_set && tick && !btn_mode && !btn_inc),
        .hit   (idle_hit)
    );
`else
    // No idle exit; TIMEOUT only matters when the timeout is built in.
    assign idle_hit = 1'b0 && (TIMEOUT == 0);
`endif

    // Blink: a button press or timeout restarts the phase so the edited
    // value is shown unblanked right away.
    hm_tick_cnt #(.CW(CW), .LIMIT(BLINK)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_run || btn_mode || btn_inc || idle_hit),
        .en    (in_set && tick && !btn_mode && !btn_inc && !idle_hit),
        .hit   (blink_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN_H;
            blank <= 1'b0;
            inc_h <= 1'b0;
            inc_m <= 1'b0;
        end else begin
            state <= next_state;
            blank <= next_blank;
            inc_h <= next_inc_h;
            inc_m <= next_inc_m;
        end
    end

    always_comb begin
        next_state = state;
        next_blank = blank;
        next_inc_h = 1'b0;
        next_inc_m = 1'b0;
        case (state)
            ST_RUN_H, ST_RUN_M: begin
                next_blank = 1'b0;
                if (btn_mode) begin
                    next_state = ST_SET_H;
                end else if (dwell_hit) begin
                    next_state = (state == ST_RUN_H) ? ST_RUN_M : ST_RUN_H;
                end
            end
            ST_SET_H, ST_SET_M: begin
                // Priority: mode change, then increment, then timeout, then blink.
                if (btn_mode) begin
                    next_state = (state == ST_SET_H) ? ST_SET_M : ST_RUN_H;
                    next_blank = 1'b0;
                end else if (btn_inc) begin
                    next_inc_h = (state == ST_SET_H);
                    next_inc_m = (state == ST_SET_M);
                    next_blank = 1'b0;
                end else if (idle_hit) begin
                    next_state = ST_RUN_H;
                    next_blank = 1'b0;
                end else if (blink_hit) begin
                    next_blank = !blank;
                end
            end
            default: begin
                next_state = ST_RUN_H;
                next_blank = 1'b0;
            end
        endcase
    end

    assign sel       = ((state == ST_RUN_M) || (state == ST_SET_M)) ? SEL_MIN : SEL_HOUR;
    assign set_mode  = in_set;
    assign dbg_state = state;

endmodule

// File: tb/tb_hm_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hm_disp_ctrl
//   Table of directed vectors, hand-written timeout / reset sequences and
//   random stimulus against a behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_hm_disp_ctrl;

    localparam int CW      = 6;
    localparam int DWELL   = 4;
    localparam int BLINK   = 2;
    localparam int TIMEOUT = 30;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sel, blank, inc_h, inc_m, set_mode;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    hm_disp_ctrl #(.CW(CW), .DWELL(DWELL), .BLINK(BLINK), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sel       (sel),
        .blank     (blank),
        .inc_h     (inc_h),
        .inc_m     (inc_m),
        .set_mode  (set_mode),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 RUN hours, 1 RUN minutes, 2 SET hours, 3 SET minutes
    int   m_mode;
    int   m_run_ticks, m_blink_ticks, m_idle_ticks;
    logic m_blank, m_inc_h, m_inc_m;

    task automatic model_reset();
        m_mode = 0;
        m_run_ticks = 0;
        m_blink_ticks = 0;
        m_idle_ticks = 0;
        m_blank = 1'b0;
        m_inc_h = 1'b0;
        m_inc_m = 1'b0;
    endtask

    task automatic model_clear_counts();
        m_run_ticks = 0;
        m_blink_ticks = 0;
        m_idle_ticks = 0;
    endtask

    task automatic model_step(input logic t, input logic m, input logic i);
        bit timed_out;
        m_inc_h = 1'b0;
        m_inc_m = 1'b0;
        if (m_mode < 2) begin
            if (m) begin
                m_mode = 2;
                model_clear_counts();
            end else if (t) begin
                m_run_ticks++;
                if (m_run_ticks == DWELL) begin
                    m_mode = 1 - m_mode;
                    m_run_ticks = 0;
                end
            end
            m_blank = 1'b0;
        end else begin
            if (m) begin
                m_mode = (m_mode == 2) ? 3 : 0;
                model_clear_counts();
                m_blank = 1'b0;
            end else if (i) begin
                if (m_mode == 2) m_inc_h = 1'b1;
                else m_inc_m = 1'b1;
                m_blank = 1'b0;
                model_clear_counts();
            end else if (t) begin
                timed_out = 0;
`ifdef HM_TIMEOUT_EN
                m_idle_ticks++;
                if (m_idle_ticks == TIMEOUT) timed_out = 1;
`endif
                if (timed_out) begin
                    m_mode = 0;
                    m_blank = 1'b0;
                    model_clear_counts();
                end else begin
                    m_blink_ticks++;
                    if (m_blink_ticks == BLINK) begin
                        m_blank = !m_blank;
                        m_blink_ticks = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".sel"},      int'(sel),       int'(m_mode == 1 || m_mode == 3));
        check({tag, ".blank"},    int'(blank),     int'(m_blank));
        check({tag, ".inc_h"},    int'(inc_h),     int'(m_inc_h));
        check({tag, ".inc_m"},    int'(inc_m),     int'(m_inc_m));
        check({tag, ".set_mode"}, int'(set_mode),  int'(m_mode >= 2));
        check({tag, ".state"},    int'(dbg_state), m_mode);
        check({tag, ".inc_excl"}, int'(inc_h && inc_m), 0);
    endtask

    // ---------------- driver ----------------
    // Called right after a falling edge: drive, let the rising edge sample,
    // step the model, compare at the next falling edge.
    task automatic cycle(input logic t, input logic m, input logic i, input string tag);
        tick = t;
        btn_mode = m;
        btn_inc = i;
        @(posedge clk);
        model_step(t, m, i);
        @(negedge clk);
        tick = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic t, m, i;
        logic e_sel, e_blank, e_inc_h, e_inc_m, e_set;
    } vec_t;

    vec_t vecs[31];

    task automatic fill_vecs();
        // t m i  sel blank ih im set
        vecs[0]  = '{1,0,0, 0,0,0,0,0};
        vecs[1]  = '{1,0,0, 0,0,0,0,0};
        vecs[2]  = '{1,0,0, 0,0,0,0,0};
        vecs[3]  = '{1,0,0, 1,0,0,0,0};   // 4th tick: minutes
        vecs[4]  = '{1,0,0, 1,0,0,0,0};
        vecs[5]  = '{1,0,0, 1,0,0,0,0};
        vecs[6]  = '{1,0,0, 1,0,0,0,0};
        vecs[7]  = '{1,0,0, 0,0,0,0,0};   // 8th tick: back to hours
        vecs[8]  = '{0,1,0, 0,0,0,0,1};   // enter SET_H
        vecs[9]  = '{1,0,0, 0,0,0,0,1};
        vecs[10] = '{1,0,0, 0,1,0,0,1};
        vecs[11] = '{1,0,0, 0,1,0,0,1};
        vecs[12] = '{1,0,0, 0,0,0,0,1};
        vecs[13] = '{1,0,0, 0,0,0,0,1};
        vecs[14] = '{1,0,0, 0,1,0,0,1};   // blanked
        vecs[15] = '{0,0,1, 0,0,1,0,1};   // inc while blanked
        vecs[16] = '{0,0,0, 0,0,0,0,1};
        vecs[17] = '{0,1,0, 1,0,0,0,1};   // SET_M
        vecs[18] = '{0,0,1, 1,0,0,1,1};   // inc_m pulse
        vecs[19] = '{0,0,0, 1,0,0,0,1};
        vecs[20] = '{0,1,1, 0,0,0,0,0};   // mode+inc: RUN_H, no pulse
        vecs[21] = '{0,0,1, 0,0,0,0,0};   // inc ignored in RUN
        vecs[22] = '{1,0,0, 0,0,0,0,0};
        vecs[23] = '{1,0,0, 0,0,0,0,0};
        vecs[24] = '{1,1,0, 0,0,0,0,1};   // tick+mode: button wins
        vecs[25] = '{1,0,0, 0,0,0,0,1};
        vecs[26] = '{1,0,1, 0,0,1,0,1};   // tick+inc: tick not counted
        vecs[27] = '{1,0,0, 0,0,0,0,1};
        vecs[28] = '{1,0,0, 0,1,0,0,1};
        vecs[29] = '{0,1,0, 1,0,0,0,1};   // SET_M, unblanked
        vecs[30] = '{0,1,0, 0,0,0,0,0};   // back to RUN_H
    endtask

    // ---------------- test sequence ----------------
    initial begin
        fill_vecs();
        do_reset();

        // Reset state
        check("reset.sel",      int'(sel),      0);
        check("reset.blank",    int'(blank),    0);
        check("reset.inc_h",    int'(inc_h),    0);
        check("reset.inc_m",    int'(inc_m),    0);
        check("reset.set_mode", int'(set_mode), 0);

        // Table-driven vectors
        for (int k = 0; k < 31; k++) begin
            cycle(vecs[k].t, vecs[k].m, vecs[k].i, $sformatf("vec%0d", k));
            check($sformatf("vec%0d.tsel", k),   int'(sel),      int'(vecs[k].e_sel));
            check($sformatf("vec%0d.tblank", k), int'(blank),    int'(vecs[k].e_blank));
            check($sformatf("vec%0d.tinc_h", k), int'(inc_h),    int'(vecs[k].e_inc_h));
            check($sformatf("vec%0d.tinc_m", k), int'(inc_m),    int'(vecs[k].e_inc_m));
            check($sformatf("vec%0d.tset", k),   int'(set_mode), int'(vecs[k].e_set));
        end

        // Idle timeout in SET_M
        do_reset();
        cycle(0, 1, 0, "to.m1");
        cycle(0, 1, 0, "to.m2");
        for (int k = 0; k < TIMEOUT - 1; k++) cycle(1, 0, 0, "to.tick");
        check("to.before.set_mode", int'(set_mode), 1);
        cycle(1, 0, 0, "to.last");
`ifdef HM_TIMEOUT_EN
        check("to.after.set_mode", int'(set_mode), 0);
        check("to.after.sel",      int'(sel),      0);
        check("to.after.blank",    int'(blank),    0);
`else
        check("to.after.set_mode", int'(set_mode), 1);
        check("to.after.sel",      int'(sel),      1);
        for (int k = 0; k < 2 * TIMEOUT; k++) cycle(1, 0, 0, "to.hold");
        check("to.hold.set_mode",  int'(set_mode), 1);
`endif

        // Asynchronous reset mid-SET_M while blanked
        do_reset();
        cycle(0, 1, 0, "ar.m1");
        cycle(0, 1, 0, "ar.m2");
        cycle(1, 0, 0, "ar.t1");
        cycle(1, 0, 0, "ar.t2");
        check("ar.pre.blank", int'(blank), 1);
        check("ar.pre.sel",   int'(sel),   1);
        #2 rst_n = 1'b0;
        #1;
        check("ar.now.sel",      int'(sel),      0);
        check("ar.now.blank",    int'(blank),    0);
        check("ar.now.set_mode", int'(set_mode), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Pending increment pulse dropped by reset
        cycle(0, 1, 0, "pd.m1");
        btn_inc = 1'b1;
        @(posedge clk);
        #1;
        btn_inc = 1'b0;
        check("pd.pulse.inc_h", int'(inc_h), 1);
        rst_n = 1'b0;
        #1;
        check("pd.drop.inc_h", int'(inc_h), 0);
        check("pd.drop.set_mode", int'(set_mode), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            cycle(logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 15) == 0),
                  logic'($urandom_range(0, 5) == 0),
                  "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
